// File: rtl/des_input_sched.sv
// Collects bytes from the I2C stream or SRAM into 64-bit blocks for the 3DES input.
// Optional sticky drop_err output is enabled by defining DES_INPUT_SCHED_DROP_FLAG_EN.
module des_input_sched #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              src_sel,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  blk_count,
    input  logic              i2c_byte_valid,
    input  logic [7:0]        i2c_byte,
    output logic              sram_rd_req,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic              sram_rd_ack,
    input  logic [7:0]        sram_data,
    output logic              blk_valid,
    output logic [63:0]       blk_data,
    input  logic              blk_ready,
    output logic [3:0]        byte_cnt,
    output logic              busy,
    output logic              done
`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
    ,
    output logic              drop_err
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t            state_reg, state_next;
    logic              src_reg, src_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  remain_reg, remain_next;
    logic [63:0]       shift_reg, shift_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic              capture;
    logic [7:0]        cap_byte;

    // Only the latched source can deliver a byte, and only while fetching.
    always_comb begin
        capture  = 1'b0;
        cap_byte = i2c_byte;
        if (state_reg == FETCH) begin
            if (src_reg) begin
                capture  = sram_rd_ack;
                cap_byte = sram_data;
            end else begin
                capture  = i2c_byte_valid;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        src_next    = src_reg;
        addr_next   = addr_reg;
        remain_next = remain_reg;
        shift_next  = shift_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (blk_count != '0) begin
                        src_next    = src_sel;
                        addr_next   = base_addr;
                        remain_next = blk_count;
                        shift_next  = '0;
                        cnt_next    = '0;
                        state_next  = FETCH;
                    end else begin
                        state_next  = DONE;
                    end
                end
            end
            FETCH: begin
                if (capture) begin
                    shift_next = {shift_reg[55:0], cap_byte};
                    cnt_next   = cnt_reg + 4'd1;
                    if (src_reg) begin
                        addr_next = addr_reg + 1'b1;
                    end
                    if (cnt_reg == 4'd7) begin
                        state_next = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (blk_ready) begin
                    remain_next = remain_reg - 1'b1;
                    if (remain_reg == CNT_W'(1)) begin
                        state_next = DONE;
                    end else begin
                        shift_next = '0;
                        cnt_next   = '0;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg  <= IDLE;
            src_reg    <= 1'b0;
            addr_reg   <= '0;
            remain_reg <= '0;
            shift_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            src_reg    <= src_next;
            addr_reg   <= addr_next;
            remain_reg <= remain_next;
            shift_reg  <= shift_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Decoded from the state register so reset removes the request immediately.
    assign sram_rd_req = (state_reg == FETCH) && src_reg;
    assign sram_addr   = addr_reg;
    assign blk_valid   = (state_reg == PRESENT);
    assign blk_data    = shift_reg;
    assign byte_cnt    = cnt_reg;
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);

`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
    logic drop_reg, drop_next;

    always_comb begin
        drop_next = drop_reg;
        if ((state_reg == IDLE) && start) begin
            drop_next = 1'b0;
        end else if (((state_reg == PRESENT) || (state_reg == DONE)) && !src_reg && i2c_byte_valid) begin
            drop_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_reg <= 1'b0;
        end else begin
            drop_reg <= drop_next;
        end
    end

    assign drop_err = drop_reg;
`endif

endmodule

// File: tb/tb_des_input_sched.sv
// Self-checking bench for des_input_sched: command table plus randomized commands
// scored against a byte/address model built from the memory image and I2C byte list.
module tb_des_input_sched;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start = 1'b0;
    logic              src_sel = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  blk_count = '0;
    logic              i2c_byte_valid = 1'b0;
    logic [7:0]        i2c_byte = '0;
    logic              sram_rd_req;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_rd_ack;
    logic [7:0]        sram_data;
    logic              blk_valid;
    logic [63:0]       blk_data;
    logic              blk_ready;
    logic [3:0]        byte_cnt;
    logic              busy;
    logic              done;
`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
    logic              drop_err;
`endif

    des_input_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .start          (start),
        .src_sel        (src_sel),
        .base_addr      (base_addr),
        .blk_count      (blk_count),
        .i2c_byte_valid (i2c_byte_valid),
        .i2c_byte       (i2c_byte),
        .sram_rd_req    (sram_rd_req),
        .sram_addr      (sram_addr),
        .sram_rd_ack    (sram_rd_ack),
        .sram_data      (sram_data),
        .blk_valid      (blk_valid),
        .blk_data       (blk_data),
        .blk_ready      (blk_ready),
        .byte_cnt       (byte_cnt),
        .busy           (busy),
        .done           (done)
`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
        ,
        .drop_err       (drop_err)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic [15:0] base;
        logic [7:0]  count;
        int          delay;
        int          stall;
        int          gap;
        logic        stray;
        logic        poke;
        logic        seq_bytes;
        logic [7:0]  first_byte;
        logic        check_first;
        logic [63:0] exp_first;
        logic        check_timing;
    } cmd_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  mem [0:65535];
    logic [63:0] exp_blk [$];
    logic [15:0] exp_addr [$];
    logic [7:0]  tx_q [$];

    int          ack_delay = 0;
    int          cur_stall = 0;
    int          done_cnt = 0;
    int          req_cnt = 0;
    int          first_valid_cyc = -1;
    int          last_xfer_cyc = -1;
    int          xfer_n = 0;
    logic [63:0] last_blk = '0;
    logic [63:0] first_blk = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // SRAM responder: acks after ack_delay wait cycles and checks the address stream.
    initial begin
        int          wait_cnt;
        logic [15:0] held_addr;
        wait_cnt    = 0;
        held_addr   = '0;
        sram_rd_ack = 1'b0;
        sram_data   = '0;
        forever begin
            @(negedge clk);
            if (sram_rd_req && nrst) begin
                req_cnt++;
                if (wait_cnt == 0) held_addr = sram_addr;
                else chk("sram_addr_stable", sram_addr, held_addr);
                if (wait_cnt >= ack_delay) begin
                    sram_rd_ack = 1'b1;
                    sram_data   = mem[sram_addr];
                    chk("sram_read_expected", exp_addr.size() != 0, 1);
                    if (exp_addr.size() != 0) chk("sram_addr_seq", sram_addr, exp_addr.pop_front());
                    wait_cnt = 0;
                end else begin
                    sram_rd_ack = 1'b0;
                    sram_data   = 8'($urandom);
                    wait_cnt++;
                end
            end else begin
                sram_rd_ack = 1'b0;
                wait_cnt    = 0;
            end
        end
    end

    // Block consumer: stalls cur_stall cycles per block, scores every valid cycle.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        blk_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (blk_valid) begin
                chk("byte_cnt_full", byte_cnt, 8);
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                chk("blk_expected", exp_blk.size() != 0, 1);
                if (exp_blk.size() == 0) begin
                    blk_ready = 1'b1;
                end else begin
                    chk("blk_data", blk_data, exp_blk[0]);
                    if (stall_cnt < cur_stall) begin
                        blk_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        blk_ready = 1'b1;
                        stall_cnt = 0;
                        last_blk  = exp_blk.pop_front();
                        last_xfer_cyc = cyc;
                        if (xfer_n == 0) first_blk = blk_data;
                        xfer_n++;
                    end
                end
            end else begin
                blk_ready = 1'($urandom_range(1, 0));
                stall_cnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    task automatic run_cmd(input cmd_t v);
        logic [63:0] blk;
        logic [7:0]  by;
        logic [15:0] a;
        int          s;
        int          gap_left;
        logic        finished;
        logic        expect_drop;
        exp_blk.delete();
        exp_addr.delete();
        tx_q.delete();
        for (int b = 0; b < int'(v.count); b++) begin
            blk = '0;
            for (int i = 0; i < 8; i++) begin
                if (v.src) begin
                    a = v.base + 16'(8 * b + i);
                    exp_addr.push_back(a);
                    by = mem[a];
                end else begin
                    by = v.seq_bytes ? v.first_byte + 8'(8 * b + i) : 8'($urandom);
                    tx_q.push_back(by);
                end
                blk = {blk[55:0], by};
            end
            exp_blk.push_back(blk);
        end
        ack_delay       = v.delay;
        cur_stall       = v.stall;
        first_valid_cyc = -1;
        xfer_n          = 0;
        expect_drop     = 1'b0;
        finished        = 1'b0;
        $display("cmd: src=%0d base=%h count=%0d delay=%0d stall=%0d", v.src, v.base, v.count, v.delay, v.stall);

        @(negedge clk);
        done_cnt  = 0;
        req_cnt   = 0;
        start     = 1'b1;
        src_sel   = v.src;
        base_addr = v.base;
        blk_count = v.count;
        s = cyc;
        @(negedge clk);
        start     = 1'b0;
        src_sel   = 1'($urandom);
        base_addr = 16'($urandom);
        blk_count = 8'($urandom);
        chk("busy_after_start", busy, 1);
`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
        chk("drop_err_cleared_by_start", drop_err, 0);
`endif
        gap_left = int'($urandom_range(v.gap, 0));
        for (int t = 0; t < 3000; t++) begin
`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
            if (expect_drop) begin
                chk("drop_err_set", drop_err, 1);
                expect_drop = 1'b0;
            end
`endif
            if (done) begin
                finished = 1'b1;
                break;
            end
            i2c_byte_valid = 1'b0;
            if (!v.src) begin
                if (busy && !blk_valid && tx_q.size() != 0) begin
                    if (gap_left == 0) begin
                        i2c_byte_valid = 1'b1;
                        i2c_byte       = tx_q.pop_front();
                        gap_left       = int'($urandom_range(v.gap, 0));
                    end else begin
                        gap_left--;
                    end
                end else if (blk_valid && v.stray) begin
                    i2c_byte_valid = 1'b1;
                    i2c_byte       = 8'($urandom);
                    expect_drop    = 1'b1;
                end
            end else if (v.stray) begin
                i2c_byte_valid = 1'($urandom_range(1, 0));
                i2c_byte       = 8'($urandom);
            end
            if (v.poke && t == 4) begin
                start     = 1'b1;
                src_sel   = !v.src;
                base_addr = ~v.base;
                blk_count = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start          = 1'b0;
        i2c_byte_valid = 1'b0;
        chk("cmd_completed_in_budget", finished, 1);
        chk("busy_during_done", busy, 1);
        if (v.count == 0) begin
            chk("zero_count_done_cycle", cyc - s, 1);
            chk("zero_count_no_sram_req", req_cnt, 0);
        end else begin
            chk("done_after_handshake", cyc - last_xfer_cyc, 1);
            chk("blk_data_retained", blk_data, last_blk);
        end
        chk("blocks_left", exp_blk.size(), 0);
        chk("addrs_left", exp_addr.size(), 0);
        if (v.check_first) chk("first_block_value", first_blk, v.exp_first);
        if (v.check_timing) chk("blk_valid_latency", first_valid_cyc - s, 9);
`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
        chk("drop_err_final", drop_err, (!v.src && v.stray && v.count != 0) ? 1 : 0);
`endif
        @(negedge clk);
        chk("idle_after_done_busy", busy, 0);
        chk("idle_after_done_done", done, 0);
        @(negedge clk);
        chk("done_pulse_count", done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t vec [5];
        cmd_t r;
        int   waited;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) mem[16'h0010 + i] = 8'(i + 1);

        //           src   base      cnt  dly stl gap stray poke  seq   first  chkf  exp_first               timing
        vec[0] = '{1'b1, 16'h0010, 8'd1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 64'h0102030405060708, 1'b1};
        vec[1] = '{1'b0, 16'h0000, 8'd2, 0, 5, 3, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 64'hAAABACADAEAFB0B1, 1'b0};
        vec[2] = '{1'b1, 16'hFFFE, 8'd1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 1'b0};
        vec[3] = '{1'b1, 16'h0100, 8'd2, 3, 1, 0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 64'h0, 1'b0};
        vec[4] = '{1'b1, 16'h0300, 8'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0, 1'b0};

        #12;
        chk("rst_sram_rd_req", sram_rd_req, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_data", blk_data, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef DES_INPUT_SCHED_DROP_FLAG_EN
        chk("rst_drop_err", drop_err, 0);
`endif
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_cmd(vec[i]);

        // Reset after five SRAM bytes, then a fresh I2C command.
        $display("cmd: reset after 5 bytes");
        exp_blk.delete();
        exp_addr.delete();
        ack_delay = 0;
        cur_stall = 0;
        for (int i = 0; i < 8; i++) exp_addr.push_back(16'h0200 + 16'(i));
        @(negedge clk);
        start     = 1'b1;
        src_sel   = 1'b1;
        base_addr = 16'h0200;
        blk_count = 8'd1;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while (byte_cnt != 4'd5 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_test_reached_5_bytes", byte_cnt, 5);
        nrst = 1'b0;
        #1;
        chk("midrst_sram_rd_req", sram_rd_req, 0);
        chk("midrst_sram_addr", sram_addr, 0);
        chk("midrst_blk_valid", blk_valid, 0);
        chk("midrst_blk_data", blk_data, 0);
        chk("midrst_byte_cnt", byte_cnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        exp_addr.delete();
        exp_blk.delete();
        @(negedge clk);
        nrst = 1'b1;
        r = vec[1];
        r.count = 8'd1;
        r.seq_bytes = 1'b0;
        r.check_first = 1'b0;
        r.stall = 2;
        run_cmd(r);

        for (int k = 0; k < 8; k++) begin
            r.src          = 1'($urandom);
            r.base         = 16'($urandom);
            r.count        = 8'($urandom_range(3, 0));
            r.delay        = int'($urandom_range(3, 0));
            r.stall        = int'($urandom_range(3, 0));
            r.gap          = int'($urandom_range(3, 0));
            r.stray        = 1'($urandom);
            r.poke         = (r.count != 0) ? 1'($urandom) : 1'b0;
            r.seq_bytes    = 1'b0;
            r.first_byte   = 8'h00;
            r.check_first  = 1'b0;
            r.exp_first    = 64'h0;
            r.check_timing = (r.src && r.delay == 0 && r.count != 0) ? 1'b1 : 1'b0;
            run_cmd(r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
